// File: rtl/spi_imu_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_imu_responder
// Purpose  : SPI mode-3 device that emulates the IMU register file; optional
//            STATUS_REG at 0x1E is built when IMU_RESP_STATUS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_imu_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPC,
  input  logic        CS,
  input  logic        SDI,
  output logic        SDO,
  input  logic [95:0] sensor_data,
  input  logic        sensor_valid,
  output logic [7:0]  ctrl1_xl,
  output logic [7:0]  ctrl2_g,
  output logic [7:0]  ctrl3_c,
  output logic [7:0]  ctrl4_c,
  output logic [7:0]  ctrl9_xl,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_spc_sync, r_cs_sync, r_sdi_sync;
  logic                   r_spc_q, r_cs_q;
  logic [95:0]            r_snap;
  logic [6:0]             r_rx;
  logic [2:0]             r_bitcnt;
  logic [6:0]             r_addr;
  logic [7:0]             r_tx;
  logic                   r_rw;
  logic                   r_byte_seen;
  logic [1:0]             r_status;

  logic       w_spc, w_cs, w_sdi, w_spc_rise, w_spc_fall, w_cs_rise, w_byte_done;
  logic [7:0] w_byte, w_rd_cmd, w_rd_next;
  logic [6:0] w_next_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spc_sync <= {SYNC_STAGES{1'b1}};
      r_cs_sync  <= {SYNC_STAGES{1'b1}};
      r_sdi_sync <= '0;
      r_spc_q    <= 1'b1;
      r_cs_q     <= 1'b1;
    end else begin
      r_spc_sync <= {r_spc_sync[SYNC_STAGES-2:0], SPC};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
      r_spc_q    <= w_spc;
      r_cs_q     <= w_cs;
    end
  end

  assign w_spc       = r_spc_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_spc_rise  = w_spc & ~r_spc_q;
  assign w_spc_fall  = ~w_spc & r_spc_q;
  assign w_cs_rise   = w_cs & ~r_cs_q;
  assign w_byte      = {r_rx, w_sdi};
  assign w_byte_done = w_spc_rise && (r_bitcnt == 3'd7);
  assign w_next_addr = ctrl3_c[2] ? r_addr + 7'd1 : r_addr;

  function automatic logic [7:0] reg_read(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      7'h0F: v = WHO_AM_I_VAL;
      7'h10: v = ctrl1_xl;
      7'h11: v = ctrl2_g;
      7'h12: v = ctrl3_c;
      7'h13: v = ctrl4_c;
      7'h18: v = ctrl9_xl;
`ifdef IMU_RESP_STATUS_EN
      7'h1E: v = {6'b0, r_status};
`endif
      7'h22: v = r_snap[87:80];
      7'h23: v = r_snap[95:88];
      7'h24: v = r_snap[71:64];
      7'h25: v = r_snap[79:72];
      7'h26: v = r_snap[55:48];
      7'h27: v = r_snap[63:56];
      7'h28: v = r_snap[39:32];
      7'h29: v = r_snap[47:40];
      7'h2A: v = r_snap[23:16];
      7'h2B: v = r_snap[31:24];
      7'h2C: v = r_snap[7:0];
      7'h2D: v = r_snap[15:8];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_comb begin
    w_rd_cmd  = reg_read(w_byte[6:0]);
    w_rd_next = reg_read(w_next_addr);
  end

`ifdef IMU_RESP_STATUS_EN
  logic [11:0] r_cov;
  logic [3:0]  w_cov_idx;
  logic        w_in_sensor;
  logic [1:0]  w_status_clr;

  assign w_cov_idx    = 4'(r_addr - 7'h22);
  assign w_in_sensor  = (r_addr >= 7'h22) && (r_addr <= 7'h2D);
  // bit1 GDA needs 0x22..0x27 fully read, bit0 XLDA needs 0x28..0x2D
  assign w_status_clr = (r_state == S_END && r_rw) ? {&r_cov[5:0], &r_cov[11:6]} : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_status <= 2'b00;
      r_cov    <= '0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | {2{sensor_valid}};
      if (r_state == S_IDLE && !w_cs)
        r_cov <= '0;
      else if (r_state == S_DATA && w_byte_done && r_rw && w_in_sensor)
        r_cov <= r_cov | (12'd1 << w_cov_idx);
    end
  end
`else
  logic w_unused_sensor_valid;
  assign w_unused_sensor_valid = sensor_valid;
  assign r_status = 2'b00;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_rx        <= '0;
      r_bitcnt    <= '0;
      r_addr      <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_byte_seen <= 1'b0;
      SDO         <= 1'b0;
      frame_done  <= 1'b0;
      ctrl1_xl    <= 8'h00;
      ctrl2_g     <= 8'h00;
      ctrl3_c     <= 8'h04;
      ctrl4_c     <= 8'h00;
      ctrl9_xl    <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        // CS is checked as a level so a fall landing during END is not lost
        S_IDLE: if (!w_cs) begin
          r_snap      <= sensor_data;
          r_bitcnt    <= '0;
          r_byte_seen <= 1'b0;
          r_state     <= S_CMD;
        end
        S_CMD: begin
          if (w_spc_rise) begin
            r_rx     <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          if (w_byte_done) begin
            r_rw        <= w_byte[7];
            r_addr      <= w_byte[6:0];
            r_tx        <= w_rd_cmd;
            r_byte_seen <= 1'b1;
            r_state     <= S_DATA;
          end
          if (w_cs_rise) r_state <= S_END;
        end
        S_DATA: begin
          if (w_spc_fall && r_rw) begin
            SDO  <= r_tx[7];
            r_tx <= {r_tx[6:0], 1'b0};
          end
          if (w_spc_rise) begin
            r_rx     <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          if (w_byte_done) begin
            if (!r_rw) begin
              case (r_addr)
                7'h10: ctrl1_xl <= w_byte;
                7'h11: ctrl2_g  <= w_byte;
                7'h12: ctrl3_c  <= w_byte;
                7'h13: ctrl4_c  <= w_byte;
                7'h18: ctrl9_xl <= w_byte;
                default: ;
              endcase
            end
            r_addr <= w_next_addr;
            r_tx   <= w_rd_next;
          end
          if (w_cs_rise) r_state <= S_END;
        end
        S_END: begin
          frame_done <= r_byte_seen;
          SDO        <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_imu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_imu_responder
// Purpose  : Self-checking bench for spi_imu_responder against a byte-level
//            register-map model; status tests built with IMU_RESP_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_imu_responder;

  localparam int c_half = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        SPC = 1'b1, CS = 1'b1, SDI = 1'b0, sensor_valid = 1'b0;
  logic        SDO, frame_done;
  logic [95:0] sensor_data = '0;
  logic [7:0]  ctrl1_xl, ctrl2_g, ctrl3_c, ctrl4_c, ctrl9_xl;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int cs_hi = 0;

  logic [7:0] tx_buf [0:15];
  logic [7:0] rx_buf [0:15];
  logic [7:0] exp_rd [0:15];
  logic [7:0] m_mem  [0:127];
  logic [7:0] m_status = 8'h00;
  int         n_exp;

  logic [6:0] waddrs [0:8] = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h18, 7'h0F, 7'h22, 7'h2D, 7'h1E};
  logic [6:0] raddrs [0:7] = '{7'h0F, 7'h10, 7'h12, 7'h18, 7'h22, 7'h26, 7'h2A, 7'h7C};

  always #5 clk = ~clk;

  spi_imu_responder #(.WHO_AM_I_VAL(8'h6A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SPC(SPC), .CS(CS), .SDI(SDI), .SDO(SDO),
    .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .ctrl1_xl(ctrl1_xl), .ctrl2_g(ctrl2_g), .ctrl3_c(ctrl3_c),
    .ctrl4_c(ctrl4_c), .ctrl9_xl(ctrl9_xl), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (reset && frame_done) fd_count <= fd_count + 1;

  // SDO must be quiet once CS has been high for a while
  always @(negedge clk) begin
    if (CS && reset) begin
      cs_hi <= cs_hi + 1;
      if (cs_hi == 10) check("sdo_idle", {31'b0, SDO}, 32'd0);
    end else cs_hi <= 0;
  end

  function automatic bit m_writable(input logic [6:0] a);
    return a inside {7'h10, 7'h11, 7'h12, 7'h13, 7'h18};
  endfunction

  function automatic logic [7:0] m_reg(input logic [6:0] a, input logic [95:0] s);
    int k;
    logic [15:0] f;
    if (a == 7'h0F) return 8'h6A;
    if (m_writable(a)) return m_mem[a];
    if (a == 7'h1E) return m_status;
    if (a >= 7'h22 && a <= 7'h2D) begin
      k = int'(a) - 'h22;
      f = 16'(s >> (80 - 16 * (k / 2)));
      return (k % 2 == 1) ? f[15:8] : f[7:0];
    end
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
    m_mem[7'h12] = 8'h04;
  endtask

  task automatic model_frame(input int nbits, input logic [95:0] snap);
    logic [6:0] a;
    logic rw, inc;
    int nfull;
    a = tx_buf[0][6:0];
    rw = tx_buf[0][7];
    nfull = (nbits / 8) - 1;
    for (int i = 1; i <= nfull; i++) begin
      inc = m_mem[7'h12][2];
      if (rw) exp_rd[i] = m_reg(a, snap);
      else if (m_writable(a)) m_mem[a] = tx_buf[i];
      if (inc) a = a + 7'd1;
    end
    n_exp = rw ? nfull : 0;
  endtask

  task automatic spi_xfer(input int nbits, input bit hold_cs, input bit scramble);
    for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
    @(negedge clk); CS = 1'b0;
    repeat (c_half) @(posedge clk);
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk); SPC = 1'b0; SDI = tx_buf[b / 8][7 - (b % 8)];
      repeat (c_half) @(posedge clk);
      @(negedge clk); rx_buf[b / 8] = {rx_buf[b / 8][6:0], SDO}; SPC = 1'b1;
      repeat (c_half) @(posedge clk);
      if (scramble && b == 7) sensor_data = {$urandom, $urandom, $urandom};
    end
    if (!hold_cs) begin
      @(negedge clk); CS = 1'b1; SDI = 1'b0;
      repeat (12) @(posedge clk);
    end
  endtask

  task automatic do_frame(input int nbits, input bit scramble);
    logic [95:0] snap;
    int fd0;
    snap = sensor_data;
    model_frame(nbits, snap);
    fd0 = fd_count;
    spi_xfer(nbits, 1'b0, scramble);
    for (int i = 1; i <= n_exp; i++) check("rd_byte", {24'b0, rx_buf[i]}, {24'b0, exp_rd[i]});
    check("ctrl1_xl", {24'b0, ctrl1_xl}, {24'b0, m_mem[7'h10]});
    check("ctrl2_g",  {24'b0, ctrl2_g},  {24'b0, m_mem[7'h11]});
    check("ctrl3_c",  {24'b0, ctrl3_c},  {24'b0, m_mem[7'h12]});
    check("ctrl4_c",  {24'b0, ctrl4_c},  {24'b0, m_mem[7'h13]});
    check("ctrl9_xl", {24'b0, ctrl9_xl}, {24'b0, m_mem[7'h18]});
    check("frame_done_cnt", fd_count - fd0, (nbits >= 8) ? 1 : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sdo"}, {31'b0, SDO}, 32'd0);
    check({tag, "_fd"}, {31'b0, frame_done}, 32'd0);
    check({tag, "_ctrl1"}, {24'b0, ctrl1_xl}, 32'h00);
    check({tag, "_ctrl2"}, {24'b0, ctrl2_g}, 32'h00);
    check({tag, "_ctrl3"}, {24'b0, ctrl3_c}, 32'h04);
    check({tag, "_ctrl4"}, {24'b0, ctrl4_c}, 32'h00);
    check({tag, "_ctrl9"}, {24'b0, ctrl9_xl}, 32'h00);
  endtask

  initial begin
    int kind, n;
    logic [6:0] a;
    m_reset();
    for (int i = 0; i < 16; i++) tx_buf[i] = 8'h00;
    repeat (4) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);

    // WHO_AM_I
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00;
    do_frame(16, 1'b0);
    check("who_am_i", {24'b0, rx_buf[1]}, 32'h6A);

    // write then read back CTRL1_XL
    tx_buf[0] = 8'h10; tx_buf[1] = 8'h50;
    do_frame(16, 1'b0);
    check("ctrl1_after_write", {24'b0, ctrl1_xl}, 32'h50);
    tx_buf[0] = 8'h90; tx_buf[1] = 8'hA5;
    do_frame(16, 1'b0);
    check("ctrl1_readback", {24'b0, rx_buf[1]}, 32'h50);

    // burst of all sensor bytes, sensor_data scrambled mid-frame
    sensor_data = 96'h0102_0304_0506_0708_090A_0B0C;
    tx_buf[0] = 8'hA2;
    for (int i = 1; i <= 12; i++) tx_buf[i] = 8'($urandom);
    do_frame(8 * 13, 1'b1);
    for (int i = 0; i < 12; i++)
      check("burst_literal", {24'b0, rx_buf[i + 1]}, (i % 2 == 0) ? i + 2 : i);

    // IF_INC off: address holds
    sensor_data = 96'h0102_0304_0506_0708_090A_0B0C;
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h00;
    do_frame(16, 1'b0);
    tx_buf[0] = 8'hA2;
    do_frame(32, 1'b0);
    for (int i = 1; i <= 3; i++) check("noinc_literal", {24'b0, rx_buf[i]}, 32'h02);
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h04;
    do_frame(16, 1'b0);

    // partial data byte is discarded
    tx_buf[0] = 8'h13; tx_buf[1] = 8'hFF;
    do_frame(13, 1'b0);
    check("partial_ctrl4", {24'b0, ctrl4_c}, 32'h00);

    // randomized frames
    repeat (30) begin
      kind = $urandom_range(0, 2);
      sensor_data = {$urandom, $urandom, $urandom};
      if (kind == 0) begin
        a = ($urandom_range(0, 9) == 9) ? 7'($urandom) : waddrs[$urandom_range(0, 8)];
        tx_buf[0] = {1'b0, a};
        tx_buf[1] = 8'($urandom);
        n = 1;
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : raddrs[$urandom_range(0, 7)];
        tx_buf[0] = {1'b1, a};
        n = $urandom_range(1, 12);
        for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
      end
      do_frame(8 * (n + 1), 1'b1);
    end

    // reset in the middle of data byte 2 of a read
    sensor_data = {96{1'b1}};
    tx_buf[0] = 8'hA2; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_xfer(19, 1'b1, 1'b0);
    check("pre_reset_sdo", {31'b0, SDO}, 32'd1);
    @(negedge clk); reset = 1'b0;
    #1 check_reset_vals("midreset");
    m_reset();
    CS = 1'b1; SPC = 1'b1; SDI = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00;
    do_frame(16, 1'b0);
    check("who_after_reset", {24'b0, rx_buf[1]}, 32'h6A);

`ifdef IMU_RESP_STATUS_EN
    @(negedge clk); sensor_valid = 1'b1;
    @(negedge clk); sensor_valid = 1'b0;
    m_status = 8'h03;
    tx_buf[0] = 8'h9E; tx_buf[1] = 8'h00;
    do_frame(16, 1'b0);
    check("status_set", {24'b0, rx_buf[1]}, 32'h03);
    tx_buf[0] = 8'hA2;
    do_frame(8 * 13, 1'b0);
    m_status = 8'h00;
    tx_buf[0] = 8'h9E;
    do_frame(16, 1'b0);
    check("status_clr", {24'b0, rx_buf[1]}, 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_imu_responder.md
Name: spi_imu_responder

Overview:
- SPI mode-3 responder that emulates the IMU register interface. It is the device end of the link driven by our IMU SPI initiator.
- Accepts single-byte config writes and auto-incrementing multi-byte reads of the 12 gyro/accel output bytes (0x22..0x2D).
- Serves as a bench/FPGA stand-in for the physical IMU, so the read path runs without hardware.
- All SPI pins are oversampled in the `clk` domain.

Parameters:
- WHO_AM_I_VAL, 8'h6A, value returned at address 0x0F.
- SYNC_STAGES, 2, synchronizer depth on SPC/CS/SDI (minimum 2).

Ports:
- clk  input  1  system clock; SPC frequency must not exceed clk/8.
- reset  input  1  asynchronous, active-low reset.
- SPC  input  1  serial clock from initiator; idles high.
- CS  input  1  chip select; 0 = frame active.
- SDI  input  1  serial data from initiator, MSB first.
- SDO  output  1  serial data to initiator, MSB first.
- sensor_data  input  96  {pitch, roll, yaw, x, y, z}, 16 bits each, pitch in [95:80]. Each field maps to {H,L} register pairs 0x22..0x2D.
- sensor_valid  input  1  one-cycle pulse: new sensor_data available.
- ctrl1_xl, ctrl2_g, ctrl3_c, ctrl4_c, ctrl9_xl  output  8 each  current contents of 0x10, 0x11, 0x12, 0x13, 0x18.
- frame_done  output  1  one-cycle pulse when CS deasserts after ≥1 complete byte.

Behaviour:
- Reset (reset==0, asynchronous):
  - SDO=0, frame_done=0.
  - All ctrl regs = 8'h00, except ctrl3_c = 8'h04 (IF_INC=1).
  - Snapshot = 0, FSM = IDLE.
- Input sampling: SPC, CS, SDI each pass through SYNC_STAGES flops. Edges are detected on the synchronized SPC/CS; all actions below refer to synchronized edges.
- FSM states IDLE, CMD, DATA, END:
  - IDLE: on CS fall, latch snapshot <= sensor_data, clear bit counter, go to CMD.
  - CMD: shift SDI on each SPC rise. On the 8th rise, rw = bit7 (1 = read) and addr = bits[6:0]. If rw=1, load tx_shift <= reg(addr). Go to DATA.
  - DATA, read: on each SPC fall, SDO <= tx_shift[7] and tx_shift shifts left. The first fall after the command byte drives the MSB. After the 8th rise of each data byte, addr <= addr+1 (7-bit wrap 0x7F->0x00) and tx_shift <= reg(new addr).
  - DATA, write: on the 8th rise of each data byte, commit the byte to addr if it is writable, then addr <= addr+1.
  - Address increment happens only if ctrl3_c[2]=1; otherwise addr holds.
  - Any state, CS rise: discard the partial byte (no write), go to END.
  - END: pulse frame_done for 1 clk if ≥1 full byte was received, SDO <= 0, go to IDLE.
- SDO latency: updated ≤ SYNC_STAGES+2 clk after the SPC falling edge at the pin. It holds between falls and is 0 while CS=1.
- Register map (reg(addr)):
  - 0x0F -> WHO_AM_I_VAL.
  - 0x10, 0x11, 0x12, 0x13, 0x18 -> ctrl regs (read/write).
  - 0x22 -> snapshot pitch[7:0], 0x23 -> pitch[15:8], and so on through 0x2D -> z[15:8].
  - All other addresses read 8'h00; writes to them are ignored.
  - Writes to 0x0F and 0x22..0x2D are ignored.
- Snapshot consistency: sensor_data changes during a frame never affect that frame. The next frame sees the new values.
- Simultaneous events:
  - CS rise coincident with the 8th SPC rise: the byte completes and is committed first, then END.
  - CS fall while in END: handled on the next cycle in IDLE. No frame is lost, because END lasts one cycle.
- Reset mid-frame: immediate return to reset values. A frame in progress is abandoned.

Optional Feature:
- Macro IMU_RESP_STATUS_EN.
- Enabled: STATUS_REG at 0x1E, read-only.
  - bit0 XLDA and bit1 GDA are set by sensor_valid.
  - Both bits are cleared when a read frame's snapshot is taken and that frame's address range covers 0x28..0x2D (XLDA) or 0x22..0x27 (GDA). Clearing takes effect at frame end.
  - If sensor_valid arrives in the same cycle as a clear, set wins.
- Disabled: 0x1E reads 8'h00, sensor_valid is ignored, and no status logic is synthesized.

Test Plan:
- Reset released, read frame 0x8F + 1 dummy byte -> SDO byte = 8'h6A; frame_done pulses once.
- Write frame 0x10, 0x50; then read 0x90 -> ctrl1_xl = 8'h50 after the write frame; read returns 8'h50.
- sensor_data = 96'h0102_0304_0506_0708_090A_0B0C_ (pattern), read 0xA2 + 12 bytes -> SDO bytes 02,01,04,03,...,0C,0B. sensor_data changed mid-frame -> no effect on bytes.
- Write 0x12 = 8'h00 (IF_INC off), read 0xA2 + 3 bytes -> three bytes all = pitch[7:0].
- Write frame 0x13, then CS rises after 5 data bits -> ctrl4_c unchanged (8'h00); frame_done = 1 (command byte complete).
- Assert reset mid-read at bit 3 of data byte 2 -> SDO=0 and ctrl regs at reset values immediately; the next full read 0x8F returns 8'h6A. With IMU_RESP_STATUS_EN: sensor_valid pulse, read 0x9E -> 8'h03; read 0xA2 + 12 bytes, read 0x9E again -> 8'h00.
